// File: rtl/tile_scan_gen.sv
// VGA raster counters plus a two-stage pixel pipeline that maps the 4x4 tile grid
// onto ROM address/area/case, with sync delayed to match the ROM read latency.
module tile_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int GRID_X0   = 192,
  parameter int GRID_Y0   = 112
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [63:0] board_state,
  output logic [11:0] addr,
  output logic [5:0]  area,
  output logic [9:0]  romcase,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST    = 12'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST    = 12'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_VIS_END = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS_END = 12'(V_VISIBLE);
  localparam logic [11:0] HS_LO     = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_HI     = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] VS_LO     = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_HI     = 12'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [11:0] GX_LO     = 12'(GRID_X0);
  localparam logic [11:0] GX_HI     = 12'(GRID_X0 + 256);
  localparam logic [11:0] GY_LO     = 12'(GRID_Y0);
  localparam logic [11:0] GY_HI     = 12'(GRID_Y0 + 256);

  logic [11:0] hcnt, vcnt;
  logic [63:0] board_q;
  logic        h_last, v_last, snap;
  logic        vis0, hs0, vs0, in_grid;
  logic [11:0] gx, gy;
  logic [3:0]  tile, expo;
  logic        hs1, vs1, vis1;

  always_comb begin
    h_last  = (hcnt == H_LAST);
    v_last  = (vcnt == V_LAST);
    snap    = pix_en && h_last && v_last;
    vis0    = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
    hs0     = !((hcnt >= HS_LO) && (hcnt < HS_HI));
    vs0     = !((vcnt >= VS_LO) && (vcnt < VS_HI));
    gx      = hcnt - GX_LO;
    gy      = vcnt - GY_LO;
    // range compare on the raw counters so a negative offset can never alias into the grid
    in_grid = vis0 && (hcnt >= GX_LO) && (hcnt < GX_HI) && (vcnt >= GY_LO) && (vcnt < GY_HI);
    tile    = {gy[7:6], gx[7:6]};
    expo    = board_q[{tile, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      board_q     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        if (snap) begin
          board_q     <= board_state;
          frame_start <= 1'b1;
        end
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? 12'd0 : vcnt + 12'd1;
        end else begin
          hcnt <= hcnt + 12'd1;
        end
      end
    end
  end

  // stage 1 feeds the ROM; stage 2 lines sync up with the ROM data one tick later
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      area     <= 6'd63;
      romcase  <= '0;
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      vis1     <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (pix_en) begin
      if (in_grid) begin
        addr    <= {gy[5:0], gx[5:0]};
        area    <= {2'b00, tile};
        romcase <= (expo <= 4'd11) ? ({6'd0, expo} + 10'd1) : 10'd0;
      end else begin
        addr    <= '0;
        area    <= 6'd63;
        romcase <= '0;
      end
      hs1      <= hs0;
      vs1      <= vs0;
      vis1     <= vis0;
      hsync    <= hs1;
      vsync    <= vs1;
      video_on <= vis1;
    end
  end

endmodule

// File: tb/tb_tile_scan_gen.sv
// Randomized bench for tile_scan_gen on a shrunken raster; an arithmetic pixel
// model plus per-frame board snapshot predicts every output each cycle.
module tb_tile_scan_gen;
  localparam int HV = 264, HF = 2, HS = 4, HB = 2;
  localparam int VV = 72,  VF = 2, VS = 2, VB = 2;
  localparam int GX = 4,   GY = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam logic [63:0] D1 = 64'h12345678_B500DFC1;
  localparam logic [63:0] D2 = 64'h9ABCDEF0_3A7B6E40;

  logic        clk = 1'b0;
  logic        rst, pix_en;
  logic [63:0] board_state;
  logic [11:0] addr;
  logic [5:0]  area;
  logic [9:0]  romcase;
  logic        hsync, vsync, video_on, frame_start;

  tile_scan_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_X0(GX), .GRID_Y0(GY)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .board_state(board_state),
    .addr(addr), .area(area), .romcase(romcase), .hsync(hsync),
    .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [5:0]  area;
    logic [9:0]  rc;
    logic        hs;
    logic        vs;
    logic        vis;
  } exp_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_pix(input int h, input int v, input logic [63:0] b);
    exp_t r;
    int gx, gy, t, e;
    r.vis = (h < HV) && (v < VV);
    r.hs  = !(h >= HV + HF && h < HV + HF + HS);
    r.vs  = !(v >= VV + VF && v < VV + VF + VS);
    gx = h - GX;
    gy = v - GY;
    if (r.vis && gx >= 0 && gx < 256 && gy >= 0 && gy < 256) begin
      t      = (gy / 64) * 4 + gx / 64;
      e      = int'((b >> (4 * t)) & 64'hF);
      r.addr = 12'((gy % 64) * 64 + gx % 64);
      r.area = 6'(t);
      r.rc   = (e < 12) ? 10'(e + 1) : 10'd0;
    end else begin
      r.addr = '0;
      r.area = 6'd63;
      r.rc   = '0;
    end
    return r;
  endfunction

  function automatic exp_t rst_val();
    exp_t r;
    r.addr = '0; r.area = 6'd63; r.rc = '0;
    r.hs = 1'b1; r.vs = 1'b1; r.vis = 1'b0;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // model state: raster position, snapshotted board, and the two pipeline slots
  int          mh, mv, s1h, s1v;
  logic [63:0] mb;
  exp_t        s1, s2;
  bit          mfs;
  int          ticks, hl, vl;

  task automatic pin3(input string nm, input int a, input int ar, input int rc);
    chk({nm, "_addr"}, int'(addr), a);
    chk({nm, "_area"}, int'(area), ar);
    chk({nm, "_romcase"}, int'(romcase), rc);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mh = 0; mv = 0; mb = '0; s1 = rst_val(); s2 = rst_val();
      s1h = -1; s1v = -1; mfs = 1'b0;
      ticks = 0; hl = 0; vl = 0;
    end else if (pix_en) begin
      s2  = s1;
      s1  = ref_pix(mh, mv, mb);
      s1h = mh;
      s1v = mv;
      mfs = (mh == HT - 1) && (mv == VT - 1);
      if (mfs) mb = board_state;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end else begin
      mfs = 1'b0;
    end
    #1;
    chk("addr", int'(addr), int'(s1.addr));
    chk("area", int'(area), int'(s1.area));
    chk("romcase", int'(romcase), int'(s1.rc));
    chk("hsync", int'(hsync), int'(s2.hs));
    chk("vsync", int'(vsync), int'(s2.vs));
    chk("video_on", int'(video_on), int'(s2.vis));
    chk("frame_start", int'(frame_start), int'(mfs));
    if (!rst && pix_en) begin
      ticks++;
      if (!hsync) hl++;
      if (!vsync) vl++;
      if (ticks % HT == 0) begin
        chk("hs_low_per_line", hl, HS);
        hl = 0;
      end
      if (ticks % (HT * VT) == 0) begin
        chk("vs_low_per_frame", vl, VS * HT);
        vl = 0;
      end
    end
    if (mb == D1) begin
      if (s1h == GX       && s1v == GY)      pin3("origin",    0,   0, 2);
      if (s1h == GX + 255 && s1v == GY + 67) pin3("t7_last",   255, 7, 12);
      if (s1h == GX - 1   && s1v == GY)      pin3("left_out",  0,  63, 0);
      if (s1h == GX + 256 && s1v == 40)      pin3("right_out", 0,  63, 0);
      if (s1h == GX       && s1v == GY - 1)  pin3("top_out",   0,  63, 0);
      if (s1h == GX + 64  && s1v == GY + 64) pin3("t5_origin", 0,   5, 1);
      if (s1h == GX + 196 && s1v == GY + 6)  pin3("t3_e13",    388, 3, 0);
      if (s1h == GX + 70  && s1v == GY + 10) pin3("t1_e12",    646, 1, 0);
    end
    if (mb == D2 && s1h == GX && s1v == GY) pin3("t0_empty", 0, 0, 1);
  end

  task automatic reset_literals(input string nm);
    chk({nm, "_hsync"}, int'(hsync), 1);
    chk({nm, "_vsync"}, int'(vsync), 1);
    chk({nm, "_video_on"}, int'(video_on), 0);
    chk({nm, "_area"}, int'(area), 63);
    chk({nm, "_romcase"}, int'(romcase), 0);
    chk({nm, "_addr"}, int'(addr), 0);
    chk({nm, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    int n, c;
    logic [63:0] r3;
    rst = 1'b1;
    pix_en = 1'b1;
    board_state = rand64();
    repeat (3) @(posedge clk);
    #2 reset_literals("rst0");
    @(negedge clk) rst = 1'b0;

    // frame A: board_state churns but only the value present at the frame end is taken
    n = 0;
    while (mb != D1 && n < HT * VT + 100) begin
      @(negedge clk);
      n++;
      board_state = (mv == VT - 1 && mh >= HT - 8) ? D1 : rand64();
    end
    if (mb != D1) chk("timeout_snap_d1", 0, 1);

    // frame B: swap board mid-frame; D1 must stay on screen until the snapshot
    n = 0;
    while (mv != 40 && n < HT * VT) begin
      @(negedge clk);
      n++;
    end
    board_state = D2;
    n = 0;
    while (mb != D2 && n < HT * VT + 100) begin
      @(negedge clk);
      n++;
    end
    if (mb != D2) chk("timeout_snap_d2", 0, 1);

    // frame C: full rate, then 1-in-4 pix_en across the frame boundary
    n = 0;
    while (mv != VT - 2 && n < HT * VT) begin
      @(negedge clk);
      n++;
    end
    r3 = rand64();
    board_state = r3;
    c = 0;
    n = 0;
    while (!(mb == r3 && mv == 3) && n < 4 * HT * 8) begin
      @(negedge clk);
      n++;
      c++;
      pix_en = (c % 4 == 0);
    end
    if (!(mb == r3 && mv == 3)) chk("timeout_slow_frame", 0, 1);

    // reset mid-frame, then random pix_en and board churn
    rst = 1'b1;
    @(posedge clk);
    #2 reset_literals("rst_mid");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      pix_en = ($urandom_range(0, 2) != 0);
      board_state = rand64();
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
